// File: rtl/vlm_arbiter_pkg.sv
// Shared bus sizing and request bundle for the VLM arbiter slice.
//   WORD_WIDTH  width of the read/write data words
//   ADDR_WIDTH  width of the byte address
//   vlm_req_t   one upstream request: en, we, addr, din
package vlm_arbiter_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    typedef struct packed {
        logic                  en;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] din;
    } vlm_req_t;

endpackage

// File: rtl/vlm_arbiter_if.sv
// One VLM (variable-latency memory) link.
//   en    request valid          (master -> slave)
//   we    write, 0 = read        (master -> slave)
//   addr  address                (master -> slave)
//   din   write data             (master -> slave)
//   hold  request not accepted   (slave -> master)
//   dout  read data, one cycle after acceptance (slave -> master)
interface vlm_arbiter_if;
    import vlm_arbiter_pkg::*;

    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] din;
    logic                  hold;
    logic [WORD_WIDTH-1:0] dout;

    modport master (output en, we, addr, din, input  hold, dout);
    modport slave  (input  en, we, addr, din, output hold, dout);

endinterface

// File: rtl/vlm_arbiter_dout_hold.sv
// Early-change read-data register for one upstream port.
//   clk, rst_n  clock, asynchronous active-low reset
//   load        this port's read data is on d this cycle
//   d           downstream read data
//   q           load ? d : last value shown (0 after reset)
module vlm_dout_hold
    import vlm_arbiter_pkg::*;
#(
    parameter int W = WORD_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_saved;

    // Data passes straight through on the return cycle and is frozen after.
    assign q = load ? d : r_saved;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_saved <= '0;
        end else begin
            r_saved <= q;
        end
    end

endmodule

// File: rtl/vlm_arbiter.sv
// Two-master to one-slave VLM arbiter (port 0 = instruction fetch,
// port 1 = data). One request is forwarded combinationally per cycle; a
// grant stays locked while the slave holds, and each read return is routed
// only to the port that issued it.
//   clk, rst_n  clock, asynchronous active-low reset
//   p0, p1      upstream links (arbiter is their slave)
//   mem         downstream link (arbiter is its master)
// Parameter FIXED_PRIO: 0 = round-robin on ties, 1 = port 1 always wins.
module vlm_arbiter
    import vlm_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    vlm_arbiter_if.slave  p0,
    vlm_arbiter_if.slave  p1,
    vlm_arbiter_if.master mem
);

    logic     r_lock;
    logic     r_lock_port;
    logic     r_last;
    logic     r_rd_pend;
    logic     r_rd_port;

    vlm_req_t req0;
    vlm_req_t req1;
    vlm_req_t fwd;
    logic     grant;
    logic     any_req;
    logic     accept;

    assign req0    = '{en: p0.en, we: p0.we, addr: p0.addr, din: p0.din};
    assign req1    = '{en: p1.en, we: p1.we, addr: p1.addr, din: p1.din};
    assign any_req = p0.en | p1.en;

    always_comb begin
        grant = 1'b0;
        if (r_lock) begin
            grant = r_lock_port;
        end else if (p0.en && !p1.en) begin
            grant = 1'b0;
        end else if (p1.en && !p0.en) begin
            grant = 1'b1;
        end else if (p0.en && p1.en) begin
            grant = FIXED_PRIO ? 1'b1 : !r_last;
        end
    end

    // Idle bus drives zeros; en is forced to reflect any requester so a
    // locked grant keeps the slave request asserted.
    always_comb begin
        fwd = '0;
        if (any_req) begin
            fwd    = grant ? req1 : req0;
            fwd.en = 1'b1;
        end
    end

    assign mem.en   = fwd.en & rst_n;
    assign mem.we   = fwd.we;
    assign mem.addr = fwd.addr;
    assign mem.din  = fwd.din;

    assign accept   = mem.en && !mem.hold;

    always_comb begin
        p0.hold = 1'b0;
        p1.hold = 1'b0;
        if (!rst_n) begin
            p0.hold = p0.en;
            p1.hold = p1.en;
        end else begin
            if (p0.en) p0.hold = (grant == 1'b0) ? mem.hold : 1'b1;
            if (p1.en) p1.hold = (grant == 1'b1) ? mem.hold : 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock      <= 1'b0;
            r_lock_port <= 1'b0;
            r_last      <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_rd_port   <= 1'b0;
        end else begin
            if (accept) begin
                r_lock <= 1'b0;
                r_last <= grant;
            end else if (mem.en && mem.hold) begin
                r_lock      <= 1'b1;
                r_lock_port <= grant;
            end
            r_rd_pend <= accept && !mem.we;
            r_rd_port <= grant;
        end
    end

    vlm_dout_hold #(.W(WORD_WIDTH)) u_hold0 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (r_rd_pend && (r_rd_port == 1'b0)),
        .d     (mem.dout),
        .q     (p0.dout)
    );

    vlm_dout_hold #(.W(WORD_WIDTH)) u_hold1 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (r_rd_pend && (r_rd_port == 1'b1)),
        .d     (mem.dout),
        .q     (p1.dout)
    );

endmodule

// File: tb/tb_vlm_arbiter.sv
module tb_vlm_arbiter;
    import vlm_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    vlm_arbiter_if a0 ();
    vlm_arbiter_if a1 ();
    vlm_arbiter_if am ();
    vlm_arbiter_if b0 ();
    vlm_arbiter_if b1 ();
    vlm_arbiter_if bm ();

    vlm_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .p0    (a0.slave),
        .p1    (a1.slave),
        .mem   (am.master)
    );

    vlm_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .p0    (b0.slave),
        .p1    (b1.slave),
        .mem   (bm.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; inputs for the new cycle are applied after this.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        a0.en = 0; a0.we = 0; a0.addr = 0; a0.din = 0;
        a1.en = 0; a1.we = 0; a1.addr = 0; a1.din = 0;
        am.hold = 0; am.dout = 0;
        b0.en = 0; b0.we = 0; b0.addr = 0; b0.din = 0;
        b1.en = 0; b1.we = 0; b1.addr = 0; b1.din = 0;
        bm.hold = 0; bm.dout = 0;

        // Reset state
        #2;
        a0.en = 1;
        settle();
        check("rst_mem_en", 32'(am.en), 0);
        check("rst_p0_hold", 32'(a0.hold), 1);
        check("rst_p1_hold", 32'(a1.hold), 0);
        check("rst_p0_dout", a0.dout, 0);
        check("rst_p1_dout", a1.dout, 0);
        a0.en = 0;
        tick(); tick();
        rst_n = 1;

        // Single read, port 0
        a0.en = 1; a0.we = 0; a0.addr = 32'h100; am.hold = 0;
        settle();
        check("rd0_mem_en", 32'(am.en), 1);
        check("rd0_mem_addr", am.addr, 32'h100);
        check("rd0_mem_we", 32'(am.we), 0);
        check("rd0_p0_hold", 32'(a0.hold), 0);
        tick();
        a0.en = 0; am.dout = 32'hDEADBEEF;
        settle();
        check("rd0_ret_p0", a0.dout, 32'hDEADBEEF);
        check("rd0_ret_p1", a1.dout, 0);
        check("rd0_idle_en", 32'(am.en), 0);
        check("rd0_idle_addr", am.addr, 0);
        tick();
        am.dout = 32'h0;
        settle();
        check("rd0_stable_p0", a0.dout, 32'hDEADBEEF);

        // Round-robin contention: r_last = 0 so port 1 first
        a0.en = 1; a0.addr = 32'h200;
        a1.en = 1; a1.we = 0; a1.addr = 32'h300;
        settle();
        check("rr1_addr", am.addr, 32'h300);
        check("rr1_p0_hold", 32'(a0.hold), 1);
        check("rr1_p1_hold", 32'(a1.hold), 0);
        tick();
        am.dout = 32'hAAAA0001;
        settle();
        check("rr2_addr", am.addr, 32'h200);
        check("rr2_p0_hold", 32'(a0.hold), 0);
        check("rr2_p1_hold", 32'(a1.hold), 1);
        check("rr2_p1_dout", a1.dout, 32'hAAAA0001);
        check("rr2_p0_dout", a0.dout, 32'hDEADBEEF);
        tick();
        am.dout = 32'hBBBB0002;
        settle();
        check("rr3_addr", am.addr, 32'h300);
        check("rr3_p0_dout", a0.dout, 32'hBBBB0002);
        check("rr3_p1_dout", a1.dout, 32'hAAAA0001);
        tick();
        a0.en = 0; a1.en = 0; am.dout = 32'hCCCC0003;
        settle();
        check("rr4_p1_dout", a1.dout, 32'hCCCC0003);
        check("rr4_p0_dout", a0.dout, 32'hBBBB0002);
        tick();
        am.dout = 32'h0;

        // Lock under hold: r_last = 1 so port 0 wins the tie
        a0.en = 1; a0.addr = 32'h500;
        a1.en = 1; a1.addr = 32'h600;
        am.hold = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("lk%0d_addr", i), am.addr, 32'h500);
            check($sformatf("lk%0d_p0_hold", i), 32'(a0.hold), 1);
            check($sformatf("lk%0d_p1_hold", i), 32'(a1.hold), 1);
            tick();
        end
        am.hold = 0;
        settle();
        check("lk_acc_addr", am.addr, 32'h500);
        check("lk_acc_p0_hold", 32'(a0.hold), 0);
        check("lk_acc_p1_hold", 32'(a1.hold), 1);
        tick();
        a0.en = 0; am.dout = 32'h55550005;
        settle();
        check("lk_p1_addr", am.addr, 32'h600);
        check("lk_p1_hold", 32'(a1.hold), 0);
        check("lk_p0_dout", a0.dout, 32'h55550005);
        check("lk_p1_dout", a1.dout, 32'hCCCC0003);
        tick();
        a1.en = 0; am.dout = 32'h66660006;
        settle();
        check("lk_p1_ret", a1.dout, 32'h66660006);
        check("lk_p0_keep", a0.dout, 32'h55550005);
        tick();

        // Lock beats round-robin: port 1 locked while r_last = 1
        a1.en = 1; a1.addr = 32'h700; am.hold = 1;
        settle();
        tick();
        a0.en = 1; a0.we = 1; a0.addr = 32'h800; a0.din = 32'h1;
        settle();
        check("lw_addr", am.addr, 32'h700);
        check("lw_p0_hold", 32'(a0.hold), 1);
        check("lw_p1_hold", 32'(a1.hold), 1);
        am.hold = 0;
        settle();
        check("lw_p1_acc", 32'(a1.hold), 0);
        tick();
        a1.en = 0; am.dout = 32'h77770007;
        settle();
        check("lw_p1_dout", a1.dout, 32'h77770007);
        check("lw_wr_addr", am.addr, 32'h800);
        check("lw_wr_we", 32'(am.we), 1);
        check("lw_wr_din", am.din, 32'h1);
        check("lw_p0_hold2", 32'(a0.hold), 0);
        tick();
        a0.en = 0; a0.we = 0; am.dout = 32'h99;
        settle();
        check("wr_no_p0", a0.dout, 32'h55550005);
        check("wr_no_p1", a1.dout, 32'h77770007);
        tick();

        // Write then read, port 1
        a1.en = 1; a1.we = 1; a1.addr = 32'h40; a1.din = 32'h12345678;
        settle();
        check("wr1_we", 32'(am.we), 1);
        check("wr1_addr", am.addr, 32'h40);
        check("wr1_din", am.din, 32'h12345678);
        tick();
        a1.we = 0; am.dout = 32'hFFFF0000;
        settle();
        check("rd1_we", 32'(am.we), 0);
        check("rd1_p1_keep", a1.dout, 32'h77770007);
        tick();
        a1.en = 0; am.dout = 32'h12345678;
        settle();
        check("rd1_p1_ret", a1.dout, 32'h12345678);
        tick();

        // Reset in the return cycle of a port-0 read
        a0.en = 1; a0.addr = 32'h900;
        settle();
        tick();
        a0.en = 0; a1.en = 1; a1.addr = 32'hA00; am.dout = 32'hABCDEF01;
        rst_n = 0;
        settle();
        check("rm_p0_dout", a0.dout, 0);
        check("rm_p1_dout", a1.dout, 0);
        check("rm_mem_en", 32'(am.en), 0);
        check("rm_p1_hold", 32'(a1.hold), 1);
        tick();
        rst_n = 1;
        a0.en = 1; a0.addr = 32'hB00;
        settle();
        check("rm_post_p0", a0.dout, 0);
        check("rm_post_grant", am.addr, 32'hA00);
        check("rm_post_p0_hold", 32'(a0.hold), 1);
        tick();
        a0.en = 0; a1.en = 0;
        settle();
        check("rm_post_p1", a1.dout, 32'hABCDEF01);
        tick();

        // Fixed priority instance
        b0.en = 1; b0.addr = 32'hC00;
        b1.en = 1; b1.addr = 32'hD00;
        bm.hold = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("fp%0d_addr", i), bm.addr, 32'hD00);
            check($sformatf("fp%0d_p0_hold", i), 32'(b0.hold), 1);
            check($sformatf("fp%0d_p1_hold", i), 32'(b1.hold), 0);
            tick();
        end
        b0.en = 0; b1.en = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
